// File: rtl/empu_gpio_ctrl.sv
// empu_gpio_ctrl: bus-mapped GPIO with input synchroniser, edge/level interrupts and
// optional per-pin debounce, compiled in by defining GPIO_DEBOUNCE_EN.
`timescale 1ns/1ps
`default_nettype none

module empu_gpio_ctrl #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             bus_wr,
  input  logic             bus_rd,
  input  logic [2:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic             bus_rvalid,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA_IN    = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT   = 3'd1;
  localparam logic [2:0] ADDR_DIR        = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] ADDR_IRQ_TYPE   = 3'd4;
  localparam logic [2:0] ADDR_IRQ_POL    = 3'd5;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd6;
  localparam logic [2:0] ADDR_OUT_TOGGLE = 3'd7;

`ifdef GPIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // Cycles after reset until fin reflects the pads; detection is held off until then
  // and one more cycle so the edge history is seeded from real input data.
  localparam int SETTLE = SYNC_STAGES + (DB_EN ? DEBOUNCE_CYCLES : 0);
  localparam int SETTLE_W = $clog2(SETTLE + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE + 1);

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    sync_out;
  logic [WIDTH-1:0]    fin;
  logic [WIDTH-1:0]    fin_prev_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                armed;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, irq_en_q, irq_type_q, irq_pol_q;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] set_evt, w1c, rdata_d;
  logic [WIDTH-1:0] bus_rdata_q;
  logic             bus_rvalid_q;
  logic             irq_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
    logic [7:0] cnt_q;
    logic       fin_bit_q;

    // Any sample equal to the accepted value restarts the stability count.
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q     <= '0;
        fin_bit_q <= 1'b0;
      end else if (sync_out[g] != fin_bit_q) begin
        if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
          fin_bit_q <= sync_out[g];
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end

    assign fin[g] = fin_bit_q;
  end
`else
  assign fin = sync_out;
`endif

  assign armed = (settle_q == SETTLE_DONE);

  always_comb begin
    set_evt = '0;
    if (armed) begin
      set_evt = (irq_type_q & ((irq_pol_q & fin & ~fin_prev_q) |
                               (~irq_pol_q & ~fin & fin_prev_q))) |
                (~irq_type_q & ~(fin ^ irq_pol_q));
    end
    w1c = (bus_wr && bus_addr == ADDR_IRQ_STATUS) ? bus_wdata : '0;
    // A set event in the same cycle as a clear wins.
    status_d = (status_q & ~w1c) | set_evt;

    data_out_d = data_out_q;
    if (bus_wr && bus_addr == ADDR_DATA_OUT) begin
      data_out_d = bus_wdata;
    end else if (bus_wr && bus_addr == ADDR_OUT_TOGGLE) begin
      data_out_d = data_out_q ^ bus_wdata;
    end

    rdata_d = '0;
    case (bus_addr)
      ADDR_DATA_IN:    rdata_d = fin;
      ADDR_DATA_OUT:   rdata_d = data_out_q;
      ADDR_DIR:        rdata_d = dir_q;
      ADDR_IRQ_EN:     rdata_d = irq_en_q;
      ADDR_IRQ_TYPE:   rdata_d = irq_type_q;
      ADDR_IRQ_POL:    rdata_d = irq_pol_q;
      ADDR_IRQ_STATUS: rdata_d = status_q;
      default:         rdata_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_type_q   <= '0;
      irq_pol_q    <= '0;
      status_q     <= '0;
      fin_prev_q   <= '0;
      settle_q     <= '0;
      bus_rdata_q  <= '0;
      bus_rvalid_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      status_q     <= status_d;
      fin_prev_q   <= fin;
      irq_q        <= |(status_q & irq_en_q);
      bus_rvalid_q <= bus_rd;
      if (bus_rd) bus_rdata_q <= rdata_d;
      if (!armed) settle_q <= settle_q + 1'b1;
      if (bus_wr) begin
        case (bus_addr)
          ADDR_DIR:      dir_q      <= bus_wdata;
          ADDR_IRQ_EN:   irq_en_q   <= bus_wdata;
          ADDR_IRQ_TYPE: irq_type_q <= bus_wdata;
          ADDR_IRQ_POL:  irq_pol_q  <= bus_wdata;
          default: ;
        endcase
      end
    end
  end

  assign gpio_o     = data_out_q;
  assign gpio_oe    = dir_q;
  assign bus_rdata  = bus_rdata_q;
  assign bus_rvalid = bus_rvalid_q;
  assign irq        = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_empu_gpio_ctrl.sv
// tb_empu_gpio_ctrl: directed scenarios plus randomized traffic against a cycle-level
// behavioural model of the GPIO controller.
`timescale 1ns/1ps
`default_nettype none

module tb_empu_gpio_ctrl;
  localparam int W = 16;
  localparam int S = 2;
  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DLAT = D;
`else
  localparam int DLAT = 0;
`endif
  localparam int SETTLE = S + DLAT;

  logic         sys_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         bus_wr = 1'b0;
  logic         bus_rd = 1'b0;
  logic [2:0]   bus_addr = 3'd0;
  logic [W-1:0] bus_wdata = '0;
  logic [W-1:0] gpio_i = '0;
  logic [W-1:0] bus_rdata, gpio_o, gpio_oe;
  logic         bus_rvalid, irq;

  int n_vec = 0;
  int n_err = 0;

  empu_gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe),
    .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_dout, m_dir, m_en, m_type, m_pol, m_stat, m_prev, m_rdata;
  logic [W-1:0] m_fin, m_raw, m_set, m_clr, m_rv;
  logic         m_rvalid, m_irq;
  int           m_k;
`ifdef GPIO_DEBOUNCE_EN
  logic [W-1:0] m_fin_db;
  int           m_cnt[W];
`endif

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      repeat (S) m_q.push_back('0);
      {m_dout, m_dir, m_en, m_type, m_pol, m_stat, m_prev, m_rdata} = '0;
      m_rvalid = 1'b0;
      m_irq    = 1'b0;
      m_k      = 0;
`ifdef GPIO_DEBOUNCE_EN
      m_fin_db = '0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
`endif
    end else begin
      m_raw = m_q[0];
`ifdef GPIO_DEBOUNCE_EN
      m_fin = m_fin_db;
`else
      m_fin = m_raw;
`endif
      if (m_k < 100000) m_k = m_k + 1;
      m_set = '0;
      // Events count only once fin has been valid for a full cycle before this edge.
      if (m_k >= SETTLE + 2) begin
        for (int i = 0; i < W; i++) begin
          if (m_type[i]) m_set[i] = m_pol[i] ? (m_fin[i] && !m_prev[i]) : (!m_fin[i] && m_prev[i]);
          else           m_set[i] = (m_fin[i] == m_pol[i]);
        end
      end
      m_clr = (bus_wr && bus_addr == 3'd6) ? bus_wdata : '0;
      case (bus_addr)
        3'd0: m_rv = m_fin;
        3'd1: m_rv = m_dout;
        3'd2: m_rv = m_dir;
        3'd3: m_rv = m_en;
        3'd4: m_rv = m_type;
        3'd5: m_rv = m_pol;
        3'd6: m_rv = m_stat;
        default: m_rv = '0;
      endcase
      if (bus_rd) m_rdata = m_rv;
      m_rvalid = bus_rd;
      m_irq    = |(m_stat & m_en);
      m_stat   = (m_stat & ~m_clr) | m_set;
      if (bus_wr) begin
        case (bus_addr)
          3'd1: m_dout = bus_wdata;
          3'd2: m_dir  = bus_wdata;
          3'd3: m_en   = bus_wdata;
          3'd4: m_type = bus_wdata;
          3'd5: m_pol  = bus_wdata;
          3'd7: m_dout = m_dout ^ bus_wdata;
          default: ;
        endcase
      end
      m_prev = m_fin;
`ifdef GPIO_DEBOUNCE_EN
      for (int i = 0; i < W; i++) begin
        if (m_raw[i] != m_fin_db[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == D) begin
            m_fin_db[i] = m_raw[i];
            m_cnt[i]    = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
`endif
      m_q.push_back(gpio_i);
      void'(m_q.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic wr, input logic rd, input logic [2:0] a, input logic [W-1:0] wd);
    bus_wr = wr; bus_rd = rd; bus_addr = a; bus_wdata = wd;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus_wr = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [W-1:0] d, output logic v);
    step(1'b0, 1'b1, a, '0);
    d = bus_rdata;
    v = bus_rvalid;
  endtask

  task automatic apply_reset(input logic [W-1:0] g);
    @(negedge sys_clk);
    reset_n = 1'b0; gpio_i = g;
    bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 3'd0; bus_wdata = '0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    idle(SETTLE + 3);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] d;
    logic v;
    @(negedge sys_clk);
    reset_n = 1'b0; gpio_i = 16'hFFFF;
    repeat (3) @(negedge sys_clk);
    n_vec++;
    if ({gpio_o, gpio_oe, bus_rdata, bus_rvalid, irq} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got o=%h oe=%h rd=%h rv=%b irq=%b want all 0", gpio_o, gpio_oe, bus_rdata, bus_rvalid, irq);
    end
    reset_n = 1'b1;
    idle(12);
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0000 || v !== 1'b1) begin
      n_err++;
      $display("FAIL reset_no_status: got %h rv=%b want 0000 rv=1", d, v);
    end
    rd_reg(3'd0, d, v);
    n_vec++;
    if (d !== 16'hFFFF) begin
      n_err++;
      $display("FAIL reset_data_in: got %h want FFFF", d);
    end
  endtask

  task automatic test_out_toggle();
    logic [W-1:0] d;
    logic v;
    apply_reset(16'hFFFF);
    step(1'b1, 1'b0, 3'd2, 16'h00FF);
    step(1'b1, 1'b0, 3'd1, 16'h00A5);
    step(1'b1, 1'b0, 3'd7, 16'h000F);
    n_vec++;
    if (gpio_oe !== 16'h00FF || gpio_o !== 16'h00AA || bus_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL toggle_pins: got oe=%h o=%h rv=%b want oe=00FF o=00AA rv=0", gpio_oe, gpio_o, bus_rvalid);
    end
    rd_reg(3'd1, d, v);
    n_vec++;
    if (d !== 16'h00AA || v !== 1'b1) begin
      n_err++;
      $display("FAIL toggle_read: got %h rv=%b want 00AA rv=1", d, v);
    end
    idle(1);
    n_vec++;
    if (bus_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rvalid_pulse: got %b want 0", bus_rvalid);
    end
    step(1'b1, 1'b0, 3'd0, 16'h1234);
    rd_reg(3'd7, d, v);
    n_vec++;
    if (d !== 16'h0000 || gpio_o !== 16'h00AA) begin
      n_err++;
      $display("FAIL no_side_effect: got rd=%h o=%h want 0000 00AA", d, gpio_o);
    end
    rd_reg(3'd0, d, v);
    n_vec++;
    if (d !== 16'hFFFF) begin
      n_err++;
      $display("FAIL data_in_ro: got %h want FFFF", d);
    end
  endtask

  task automatic test_edge_irq();
    logic [W-1:0] d;
    logic v;
    int first;
    apply_reset(16'hFFF7);
    step(1'b1, 1'b0, 3'd4, 16'h0008);
    step(1'b1, 1'b0, 3'd5, 16'h0008);
    step(1'b1, 1'b0, 3'd3, 16'h0008);
    step(1'b1, 1'b0, 3'd6, 16'hFFFF);
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0000 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL edge_idle: got status=%h irq=%b want 0000 0", d, irq);
    end
    gpio_i = 16'hFFFF;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      if (irq === 1'b1 && first == 0) first = i;
    end
    n_vec++;
    if (first != SETTLE + 2) begin
      n_err++;
      $display("FAIL edge_irq_latency: got %0d want %0d", first, SETTLE + 2);
    end
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0008) begin
      n_err++;
      $display("FAIL edge_status: got %h want 0008", d);
    end
    step(1'b1, 1'b0, 3'd6, 16'h0008);
    idle(1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL edge_irq_clear: got %b want 0", irq);
    end
    idle(6);
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0000) begin
      n_err++;
      $display("FAIL edge_no_reset: got %h want 0000", d);
    end
  endtask

  task automatic test_level_w1c();
    logic [W-1:0] d;
    logic v;
    int bad;
    apply_reset(16'hFFFE);
    step(1'b1, 1'b0, 3'd3, 16'h0001);
    idle(2);
    step(1'b1, 1'b0, 3'd6, 16'h0001);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (irq !== 1'b1) bad++;
      idle(1);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL level_irq_hold: got %0d low cycles want 0", bad);
    end
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0001) begin
      n_err++;
      $display("FAIL level_status: got %h want 0001", d);
    end
  endtask

  task automatic test_set_wins();
    logic [W-1:0] d;
    logic v;
    apply_reset(16'hFFDF);
    step(1'b1, 1'b0, 3'd4, 16'h0020);
    step(1'b1, 1'b0, 3'd5, 16'h0020);
    step(1'b1, 1'b0, 3'd6, 16'hFFFF);
    gpio_i = 16'hFFFF;
    for (int i = 1; i <= SETTLE + 1; i++) begin
      if (i == SETTLE + 1) step(1'b1, 1'b0, 3'd6, 16'h0020);
      else                 idle(1);
    end
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0020) begin
      n_err++;
      $display("FAIL set_wins: got %h want 0020", d);
    end
  endtask

  task automatic test_type_change();
    logic [W-1:0] d;
    logic v;
    apply_reset(16'hFFFF);
    step(1'b1, 1'b0, 3'd4, 16'h0002);
    step(1'b1, 1'b0, 3'd6, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 3'd5, 16'h0002);
      step(1'b1, 1'b0, 3'd5, 16'h0000);
    end
    idle(2);
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0000) begin
      n_err++;
      $display("FAIL type_change: got %h want 0000", d);
    end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [W-1:0] d;
    logic v;
    apply_reset(16'hFFFF);
    step(1'b1, 1'b0, 3'd4, 16'h0004);
    step(1'b1, 1'b0, 3'd6, 16'hFFFF);
    gpio_i = 16'hFFFB;
    idle(3);
    gpio_i = 16'hFFFF;
    idle(10);
    rd_reg(3'd0, d, v);
    n_vec++;
    if (d !== 16'hFFFF) begin
      n_err++;
      $display("FAIL glitch_data_in: got %h want FFFF", d);
    end
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0000) begin
      n_err++;
      $display("FAIL glitch_status: got %h want 0000", d);
    end
    gpio_i = 16'hFFFB;
    idle(S + D + 2);
    rd_reg(3'd0, d, v);
    n_vec++;
    if (d !== 16'hFFFB) begin
      n_err++;
      $display("FAIL stable_data_in: got %h want FFFB", d);
    end
    rd_reg(3'd6, d, v);
    n_vec++;
    if (d !== 16'h0004) begin
      n_err++;
      $display("FAIL stable_status: got %h want 0004", d);
    end
  endtask
`endif

  task automatic test_random();
    apply_reset(W'($urandom));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) gpio_i = gpio_i ^ W'($urandom);
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
           3'($urandom_range(0, 7)), W'($urandom));
      n_vec++;
      if ({bus_rvalid, bus_rdata, gpio_o, gpio_oe, irq} !== {m_rvalid, m_rdata, m_dout, m_dir, m_irq}) begin
        n_err++;
        $display("FAIL random_cycle %0d: got rv=%b rd=%h o=%h oe=%h irq=%b want rv=%b rd=%h o=%h oe=%h irq=%b",
                 i, bus_rvalid, bus_rdata, gpio_o, gpio_oe, irq, m_rvalid, m_rdata, m_dout, m_dir, m_irq);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 3'd2, 16'hA5A5);
    step(1'b1, 1'b0, 3'd1, 16'h5A5A);
    bus_rd = 1'b1; bus_addr = 3'd1;
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({gpio_o, gpio_oe, bus_rdata, bus_rvalid, irq} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got o=%h oe=%h rd=%h rv=%b irq=%b want all 0", gpio_o, gpio_oe, bus_rdata, bus_rvalid, irq);
    end
    @(negedge sys_clk);
    bus_rd = 1'b0;
    reset_n = 1'b1;
    idle(1);
    n_vec++;
    if (bus_rvalid !== 1'b0 || gpio_oe !== 16'h0000) begin
      n_err++;
      $display("FAIL abandoned_read: got rv=%b oe=%h want 0 0000", bus_rvalid, gpio_oe);
    end
  endtask

  initial begin
    test_reset();
    test_out_toggle();
    test_edge_irq();
    test_level_w1c();
    test_set_wins();
    test_type_change();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got no summary want summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
